// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types, 800x600@60 timing constants and frame-buffer
// geometry for the VGA reader and the capture side.
//   hcnt_t / vcnt_t : horizontal / vertical counter types
//   fbaddr_t        : frame-buffer address (800 x 240 x 1 bit)
//   side_t          : per-pixel sideband carried alongside the RAM read
`timescale 1ns/1ps
package vga_timing_pkg;

    typedef logic [10:0] hcnt_t;
    typedef logic [9:0]  vcnt_t;
    typedef logic [17:0] fbaddr_t;

    localparam int unsigned H_VIS    = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BP     = 88;
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS    = 600;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned SRC_ROWS = 240;
    localparam int unsigned V_OFFSET = 60;
    localparam int unsigned RAM_LAT  = 2;
    localparam bit          SYNC_POS = 1'b1;
    localparam logic [2:0]  FG_RGB   = 3'b010;

    localparam int unsigned FB_WORDS = H_VIS * SRC_ROWS;

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNCP, H_BACK} hphase_e;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNCP, V_BACK} vphase_e;

    // Sideband that must stay aligned with the pixel coming back from RAM
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic in_window;
        logic frame_start;
    } side_t;

    function automatic hcnt_t to_hcnt(input int unsigned x);
        return hcnt_t'(x);
    endfunction

    function automatic vcnt_t to_vcnt(input int unsigned x);
        return vcnt_t'(x);
    endfunction

    function automatic fbaddr_t to_fbaddr(input int unsigned x);
        return fbaddr_t'(x);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters, horizontal and vertical phase FSMs,
// raw (undelayed) syncs and image-window decode.
//   clk, rst        : pixel clock, async active-high reset
//   hcount, vcount  : current scan position
//   line_end        : last cycle of the current line
//   v_in_window     : current line lies inside the line-doubled image
//   in_window       : current pixel lies inside the image
//   hsync_raw, vsync_raw : active-high syncs decoded from the phase FSMs
//   frame_start_raw : high at (0,0) only
`timescale 1ns/1ps
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS    = vga_timing_pkg::H_VIS,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_VIS    = vga_timing_pkg::V_VIS,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned SRC_ROWS = vga_timing_pkg::SRC_ROWS,
    parameter int unsigned V_OFFSET = vga_timing_pkg::V_OFFSET
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        line_end,
    output logic        v_in_window,
    output logic        in_window,
    output logic        hsync_raw,
    output logic        vsync_raw,
    output logic        frame_start_raw
);

    localparam hcnt_t H_ACT_LAST  = to_hcnt(H_VIS - 1);
    localparam hcnt_t H_FP_LAST   = to_hcnt(H_VIS + H_FP - 1);
    localparam hcnt_t H_SYNC_LAST = to_hcnt(H_VIS + H_FP + H_SYNC - 1);
    localparam hcnt_t H_LAST      = to_hcnt(H_VIS + H_FP + H_SYNC + H_BP - 1);

    localparam vcnt_t V_ACT_LAST  = to_vcnt(V_VIS - 1);
    localparam vcnt_t V_FP_LAST   = to_vcnt(V_VIS + V_FP - 1);
    localparam vcnt_t V_SYNC_LAST = to_vcnt(V_VIS + V_FP + V_SYNC - 1);
    localparam vcnt_t V_LAST      = to_vcnt(V_VIS + V_FP + V_SYNC + V_BP - 1);

    localparam vcnt_t WIN_FIRST   = to_vcnt(V_OFFSET);
    localparam vcnt_t WIN_END     = to_vcnt(V_OFFSET + 2 * SRC_ROWS);

    hphase_e h_state, h_next;
    vphase_e v_state, v_next;

    assign line_end = (hcount == H_LAST);

    // Scan counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else begin
            hcount <= line_end ? '0 : hcount + 11'd1;
            if (line_end) begin
                vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end
        end
    end

    // Phase state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state <= H_ACTIVE;
            v_state <= V_ACTIVE;
        end else begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    // Horizontal phase advances on the last count of each phase
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_ACTIVE: if (hcount == H_ACT_LAST)  h_next = H_FRONT;
            H_FRONT:  if (hcount == H_FP_LAST)   h_next = H_SYNCP;
            H_SYNCP:  if (hcount == H_SYNC_LAST) h_next = H_BACK;
            H_BACK:   if (hcount == H_LAST)      h_next = H_ACTIVE;
            default:  h_next = H_ACTIVE;
        endcase
    end

    // Vertical phase only moves at line wrap, so it changes with hcount=0
    always_comb begin
        v_next = v_state;
        if (line_end) begin
            case (v_state)
                V_ACTIVE: if (vcount == V_ACT_LAST)  v_next = V_FRONT;
                V_FRONT:  if (vcount == V_FP_LAST)   v_next = V_SYNCP;
                V_SYNCP:  if (vcount == V_SYNC_LAST) v_next = V_BACK;
                V_BACK:   if (vcount == V_LAST)      v_next = V_ACTIVE;
                default:  v_next = V_ACTIVE;
            endcase
        end
    end

    assign hsync_raw       = (h_state == H_SYNCP);
    assign vsync_raw       = (v_state == V_SYNCP);
    assign v_in_window     = (vcount >= WIN_FIRST) && (vcount < WIN_END);
    assign in_window       = v_in_window && (h_state == H_ACTIVE);
    assign frame_start_raw = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: reads the 800x240 1-bpp frame buffer and drives an
// 800x600@60 VGA port, line-doubling each source row into a centred window.
//   vgaclk, reset : pixel clock, async active-high reset
//   raddr         : registered read address (0 outside the image)
//   rdata         : pixel bit, valid RAM_LAT cycles after the scan position
//                   that produced it (the raddr register is the first of them)
//   vga_hs/vga_vs : syncs, polarity set by SYNC_POS
//   vga_r/g/b     : FG_RGB for lit pixels, black otherwise
//   frame_start   : one-cycle pulse with the pixel (0,0) on the pins
// Every pin lags the scan counters by RAM_LAT+1 cycles.
`timescale 1ns/1ps
module vga_fb_reader
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS    = vga_timing_pkg::H_VIS,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_VIS    = vga_timing_pkg::V_VIS,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned SRC_ROWS = vga_timing_pkg::SRC_ROWS,
    parameter int unsigned V_OFFSET = vga_timing_pkg::V_OFFSET,
    parameter int unsigned RAM_LAT  = vga_timing_pkg::RAM_LAT,
    parameter bit          SYNC_POS = vga_timing_pkg::SYNC_POS,
    parameter logic [2:0]  FG_RGB   = vga_timing_pkg::FG_RGB
) (
    input  logic        vgaclk,
    input  logic        reset,
    output logic [17:0] raddr,
    input  logic        rdata,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        frame_start
);

    localparam logic    SYNC_IDLE = !SYNC_POS;
    localparam vcnt_t   V_LAST    = to_vcnt(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam vcnt_t   V_OFF     = to_vcnt(V_OFFSET);
    localparam fbaddr_t LINE_STEP = to_fbaddr(H_VIS);

    hcnt_t   hcount;
    vcnt_t   vcount;
    logic    line_end;
    logic    v_in_window;
    logic    in_window;
    logic    hsync_raw;
    logic    vsync_raw;
    logic    frame_start_raw;
    logic    row_odd;
    fbaddr_t line_base;
    side_t   side_raw;
    side_t   side_last;
    side_t   side_pipe [RAM_LAT];

    vga_timing_gen #(
        .H_VIS    (H_VIS),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_VIS    (V_VIS),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SRC_ROWS (SRC_ROWS),
        .V_OFFSET (V_OFFSET)
    ) u_timing (
        .clk             (vgaclk),
        .rst             (reset),
        .hcount          (hcount),
        .vcount          (vcount),
        .line_end        (line_end),
        .v_in_window     (v_in_window),
        .in_window       (in_window),
        .hsync_raw       (hsync_raw),
        .vsync_raw       (vsync_raw),
        .frame_start_raw (frame_start_raw)
    );

    // Second display line of each doubled pair: parity of (vcount - V_OFFSET)
    assign row_odd = vcount[0] ^ V_OFF[0];

    // Row base address, stepped once per source row instead of multiplying
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            line_base <= '0;
        end else if (line_end) begin
            if (vcount == V_LAST) begin
                line_base <= '0;
            end else if (v_in_window && row_odd) begin
                line_base <= line_base + LINE_STEP;
            end
        end
    end

    // Stage 0: read address
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            raddr <= '0;
        end else begin
            raddr <= in_window ? line_base + fbaddr_t'(hcount) : '0;
        end
    end

    assign side_raw  = {hsync_raw, vsync_raw, in_window, frame_start_raw};
    assign side_last = side_pipe[RAM_LAT-1];

    // Sideband delay matching the RAM read path
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RAM_LAT); i++) begin
                side_pipe[i] <= '0;
            end
        end else begin
            side_pipe[0] <= side_raw;
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                side_pipe[i] <= side_pipe[i-1];
            end
        end
    end

    // Output register: polarity, colour and frame marker
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            vga_hs                <= SYNC_IDLE;
            vga_vs                <= SYNC_IDLE;
            {vga_r, vga_g, vga_b} <= 3'b000;
            frame_start           <= 1'b0;
        end else begin
            vga_hs                <= side_last.hsync ^ SYNC_IDLE;
            vga_vs                <= side_last.vsync ^ SYNC_IDLE;
            {vga_r, vga_g, vga_b} <= (side_last.in_window & rdata) ? FG_RGB : 3'b000;
            frame_start           <= side_last.frame_start;
        end
    end

endmodule
